// File: rtl/hd_encode_class_unit.sv
// Hyperdimensional classifier slice: binary-projection encoder, byte-loaded class
// memory, and a read controller streaming each chunk of every class vector.
module hd_encode_class_unit #(
  parameter int N_SIZE         = 16,
  parameter int M_SIZE         = 16,
  parameter int FTWIDTH        = 8,
  parameter int DIM_WIDTH      = 16,
  parameter int DIV_SIZE       = 512,
  parameter int DHV_SIZE       = 4000,
  parameter int CLASS_NUM      = 26,
  parameter int CLA_ADDR_WIDTH = 13
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         class_write,
  input  logic [FTWIDTH-1:0]           class_in,
  input  logic                         feat_valid,
  input  logic [N_SIZE+M_SIZE-1:0]     projections,
  input  logic [N_SIZE*FTWIDTH-1:0]    features,
  output logic                         write_done,
  output logic [M_SIZE*DIM_WIDTH-1:0]  enc_out,
  output logic                         enc_done,
  output logic [M_SIZE*FTWIDTH-1:0]    class_out,
  output logic                         class_valid,
  output logic [7:0]                   class_idx,
  output logic                         all_done
);

  localparam int BEATS      = DIV_SIZE / N_SIZE;
  localparam int CHUNKS     = DHV_SIZE / M_SIZE;
  localparam int ROWS_TOTAL = CLASS_NUM * CHUNKS;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CHUNK_W    = $clog2(CHUNKS + 1);
  localparam int CLASS_W    = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;
  localparam int LANE_W     = (M_SIZE > 1) ? $clog2(M_SIZE) : 1;

  typedef enum logic {IDLE, READ} state_t;

  // Class memory write pointer, kept as row/lane instead of a linear byte index
  logic [CLA_ADDR_WIDTH-1:0] wr_row_reg;
  logic [LANE_W-1:0]         wr_lane_reg;
  logic                      write_done_reg;
  logic                      wr_en;

  assign wr_en = class_write && !write_done_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_row_reg     <= '0;
      wr_lane_reg    <= '0;
      write_done_reg <= 1'b0;
    end else if (wr_en) begin
      if (wr_lane_reg == LANE_W'(M_SIZE - 1)) begin
        wr_lane_reg <= '0;
        if (wr_row_reg == CLA_ADDR_WIDTH'(ROWS_TOTAL - 1)) write_done_reg <= 1'b1;
        else                                               wr_row_reg     <= wr_row_reg + 1'b1;
      end else begin
        wr_lane_reg <= wr_lane_reg + 1'b1;
      end
    end
  end

  // Encoder beat/chunk sequencing
  logic [BEAT_W-1:0]  beat_reg;
  logic [CHUNK_W-1:0] enc_chunk_reg;
  logic               enc_done_reg;
  logic               feat_accept;
  logic               last_beat;

  assign feat_accept = feat_valid && write_done_reg && (enc_chunk_reg < CHUNK_W'(CHUNKS));
  assign last_beat   = (beat_reg == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_reg      <= '0;
      enc_chunk_reg <= '0;
      enc_done_reg  <= 1'b0;
    end else begin
      enc_done_reg <= feat_accept && last_beat;
      if (feat_accept) begin
        if (last_beat) begin
          beat_reg      <= '0;
          enc_chunk_reg <= enc_chunk_reg + 1'b1;
        end else begin
          beat_reg <= beat_reg + 1'b1;
        end
      end
    end
  end

  // Read controller
  state_t                    state_reg, state_next;
  logic [CLASS_W-1:0]        rd_class_reg, rd_class_next;
  logic [CHUNK_W-1:0]        rd_chunk_reg, rd_chunk_next;
  logic                      pending_reg, pending_next;
  logic                      all_done_reg, all_done_next;
  logic                      rd_en;
  logic [CLA_ADDR_WIDTH-1:0] rd_addr;
  logic                      class_valid_reg;
  logic [7:0]                class_idx_reg;

  assign rd_addr = CLA_ADDR_WIDTH'(rd_class_reg * CHUNKS + rd_chunk_reg);

  always_comb begin
    state_next    = state_reg;
    rd_class_next = rd_class_reg;
    rd_chunk_next = rd_chunk_reg;
    pending_next  = pending_reg;
    all_done_next = all_done_reg;
    rd_en         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (enc_done_reg || pending_reg) begin
          state_next    = READ;
          pending_next  = 1'b0;
          rd_class_next = '0;
        end
      end
      READ: begin
        rd_en = 1'b1;
        // One-deep overrun buffer; a second overrun simply re-sets the same flag
        if (enc_done_reg) pending_next = 1'b1;
        if (rd_class_reg == CLASS_W'(CLASS_NUM - 1)) begin
          rd_class_next = '0;
          rd_chunk_next = rd_chunk_reg + 1'b1;
          state_next    = IDLE;
          if (rd_chunk_reg == CHUNK_W'(CHUNKS - 1)) all_done_next = 1'b1;
        end else begin
          rd_class_next = rd_class_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      rd_class_reg    <= '0;
      rd_chunk_reg    <= '0;
      pending_reg     <= 1'b0;
      all_done_reg    <= 1'b0;
      class_valid_reg <= 1'b0;
      class_idx_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      rd_class_reg    <= rd_class_next;
      rd_chunk_reg    <= rd_chunk_next;
      pending_reg     <= pending_next;
      all_done_reg    <= all_done_next;
      class_valid_reg <= rd_en;
      class_idx_reg   <= 8'(rd_class_reg);
    end
  end

  // Per-dimension lane: accumulator plus one byte-wide slice of the class memory
  genvar gi;
  generate
    for (gi = 0; gi < M_SIZE; gi++) begin : g_lane
      logic [DIM_WIDTH-1:0] beat_sum;
      logic [DIM_WIDTH-1:0] acc_reg;
      logic [FTWIDTH-1:0]   mem [ROWS_TOTAL];
      logic [FTWIDTH-1:0]   rdata_reg;

      always_comb begin
        beat_sum = '0;
        for (int n = 0; n < N_SIZE; n++) begin
          if (projections[n] ^ projections[N_SIZE + gi])
            beat_sum = beat_sum - DIM_WIDTH'(features[n*FTWIDTH +: FTWIDTH]);
          else
            beat_sum = beat_sum + DIM_WIDTH'(features[n*FTWIDTH +: FTWIDTH]);
        end
      end

      // The first beat of a chunk reloads instead of accumulating
      always_ff @(posedge clk) begin
        if (reset)            acc_reg <= '0;
        else if (feat_accept) acc_reg <= (beat_reg == '0) ? beat_sum : acc_reg + beat_sum;
      end

      always_ff @(posedge clk) begin
        if (wr_en && (wr_lane_reg == LANE_W'(gi))) mem[wr_row_reg] <= class_in;
      end

      always_ff @(posedge clk) begin
        if (reset)      rdata_reg <= '0;
        else if (rd_en) rdata_reg <= mem[rd_addr];
      end

      assign enc_out[gi*DIM_WIDTH +: DIM_WIDTH] = acc_reg;
      assign class_out[gi*FTWIDTH +: FTWIDTH]   = rdata_reg;
    end
  endgenerate

  assign write_done  = write_done_reg;
  assign enc_done    = enc_done_reg;
  assign class_valid = class_valid_reg;
  assign class_idx   = class_idx_reg;
  assign all_done    = all_done_reg;

endmodule

// File: tb/tb_hd_encode_class_unit.sv
// Directed bench for hd_encode_class_unit, built with a reduced hypervector size
// and class count so the full load/encode/read flow fits a short run.
module tb_hd_encode_class_unit;

  localparam int N      = 16;
  localparam int M      = 16;
  localparam int FT     = 8;
  localparam int DW     = 16;
  localparam int DIV    = 512;
  localparam int DHV    = 64;
  localparam int CN     = 3;
  localparam int CHUNKS = DHV / M;
  localparam int BEATS  = DIV / N;
  localparam int BYTES  = CN * DHV;

  logic              clk;
  logic              reset;
  logic              class_write;
  logic [FT-1:0]     class_in;
  logic              feat_valid;
  logic [N+M-1:0]    projections;
  logic [N*FT-1:0]   features;
  logic              write_done;
  logic [M*DW-1:0]   enc_out;
  logic              enc_done;
  logic [M*FT-1:0]   class_out;
  logic              class_valid;
  logic [7:0]        class_idx;
  logic              all_done;

  hd_encode_class_unit #(
    .N_SIZE(N), .M_SIZE(M), .FTWIDTH(FT), .DIM_WIDTH(DW), .DIV_SIZE(DIV),
    .DHV_SIZE(DHV), .CLASS_NUM(CN), .CLA_ADDR_WIDTH(13)
  ) dut (
    .clk(clk), .reset(reset), .class_write(class_write), .class_in(class_in),
    .feat_valid(feat_valid), .projections(projections), .features(features),
    .write_done(write_done), .enc_out(enc_out), .enc_done(enc_done),
    .class_out(class_out), .class_valid(class_valid), .class_idx(class_idx),
    .all_done(all_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N+M-1:0] proj;
    logic [FT-1:0]  feat;
    logic [M*DW-1:0] exp_enc;
  } vec_t;

  vec_t vecs [CHUNKS];

  int checks = 0;
  int errors = 0;
  int enc_cnt = 0;
  int rd_cnt = 0;
  bit mon_en = 1'b0;
  bit prev_valid = 1'b0;
  logic [M*FT-1:0] exp_row;
  int mc, mch;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard for encoder chunks and class reads
  always @(negedge clk) begin
    if (!reset) begin
      if (enc_done) begin
        if (mon_en) begin
          if (enc_cnt >= CHUNKS) check("extra_enc_done", 256'(enc_cnt), 256'(CHUNKS - 1));
          else                   check("enc_out", enc_out, vecs[enc_cnt].exp_enc);
        end
        enc_cnt++;
      end
      if (class_valid) begin
        if (mon_en) begin
          mc  = rd_cnt % CN;
          mch = rd_cnt / CN;
          for (int k = 0; k < M; k++) exp_row[k*FT +: FT] = 8'((mc*DHV + mch*M + k) % 251);
          check("class_idx", 256'(class_idx), 256'(mc));
          check("class_out", 256'(class_out), 256'(exp_row));
          check("all_done_at_read", 256'(all_done), 256'(rd_cnt == CHUNKS*CN - 1));
          if (mc != 0) check("valid_run", 256'(prev_valid), 256'(1));
        end
        rd_cnt++;
      end
      prev_valid = class_valid;
    end
  end

  task automatic load_class_mem();
    for (int i = 0; i < BYTES - 1; i++) begin
      class_write = 1'b1;
      class_in    = 8'(i % 251);
      @(posedge clk); #1;
    end
    class_in = 8'((BYTES - 1) % 251);
    @(negedge clk);
    check("write_done_before_last", 256'(write_done), 256'(0));
    @(posedge clk); #1;
    // Overflow write with a distinct value; later reads prove it was dropped
    class_in = 8'd9;
    @(negedge clk);
    check("write_done_after_last", 256'(write_done), 256'(1));
    @(posedge clk); #1;
    class_write = 1'b0;
    class_in    = '0;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, 8'd1, {16{16'h0200}}};
    vecs[1] = '{32'h0001_0000, 8'd1, {{15{16'h0200}}, 16'hFE00}};
    vecs[2] = '{32'h0000_0001, 8'd1, {16{16'h01C0}}};
    vecs[3] = '{32'h0001_000F, 8'd5, {{15{16'h0500}}, 16'hFB00}};

    reset = 1'b1; class_write = 1'b0; class_in = '0;
    feat_valid = 1'b0; projections = '0; features = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_write_done", 256'(write_done), 256'(0));
    check("rst_enc_out", enc_out, 256'(0));
    check("rst_outputs", 256'({enc_done, class_valid, class_idx, all_done, class_out}), 256'(0));

    // Encoder must ignore beats until the class memory is full
    @(posedge clk); #1;
    feat_valid = 1'b1; features = {16{8'd1}};
    repeat (40) @(posedge clk);
    #1 feat_valid = 1'b0;
    @(negedge clk);
    check("preload_enc_out", enc_out, 256'(0));
    check("preload_enc_done_cnt", 256'(enc_cnt), 256'(0));

    @(posedge clk); #1;
    load_class_mem();

    // Back-to-back chunks, then surplus beats that must be ignored
    mon_en = 1'b1;
    for (int v = 0; v < CHUNKS; v++) begin
      for (int b = 0; b < BEATS; b++) begin
        feat_valid  = 1'b1;
        projections = vecs[v].proj;
        features    = {16{vecs[v].feat}};
        @(posedge clk); #1;
      end
    end
    projections = '0; features = {16{8'd7}};
    repeat (40) @(posedge clk);
    #1 feat_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("enc_done_total", 256'(enc_cnt), 256'(CHUNKS));
    check("read_total", 256'(rd_cnt), 256'(CHUNKS*CN));
    check("all_done_sticky", 256'(all_done), 256'(1));
    check("enc_out_held", enc_out, vecs[CHUNKS-1].exp_enc);

    // Reset in the middle of a read pass
    mon_en = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst2_all_done", 256'(all_done), 256'(0));
    check("rst2_write_done", 256'(write_done), 256'(0));
    @(posedge clk); #1;
    load_class_mem();
    for (int b = 0; b < BEATS; b++) begin
      feat_valid = 1'b1; projections = '0; features = {16{8'd1}};
      @(posedge clk); #1;
    end
    feat_valid = 1'b0;
    for (int t = 0; t < 100 && !class_valid; t++) @(negedge clk);
    check("read_started", 256'(class_valid), 256'(1));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midread_class_valid", 256'(class_valid), 256'(0));
    check("midread_enc_out", enc_out, 256'(0));
    check("midread_outputs", 256'({enc_done, class_idx, all_done, write_done, class_out}), 256'(0));
    @(posedge clk); #1 reset = 1'b0;
    begin
      int activity = 0;
      for (int t = 0; t < 12; t++) begin
        @(negedge clk);
        if (class_valid || enc_done || all_done) activity++;
      end
      check("post_reset_quiet", 256'(activity), 256'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hd_encode_class_unit.md
Name: hd_encode_class_unit

Overview:
- Hyperdimensional-classifier datapath slice. Combines three parts:
  - a binary-projection encoder (MAC) that builds M_SIZE hypervector dimensions per chunk;
  - a byte-serially loaded class-hypervector memory;
  - a read controller that, after each encoded chunk, streams the matching chunk of every class vector to the downstream similarity checker.
- Sits between the projection/feature memories and the similarity checker.

Parameters:
- N_SIZE, 16: features consumed per beat.
- M_SIZE, 16: dimensions produced per chunk; also class bytes per memory row.
- FTWIDTH, 8: feature and class-element width (unsigned).
- DIM_WIDTH, 16: accumulator width per dimension (two's complement).
- DIV_SIZE, 512: input features per sample; BEATS = DIV_SIZE/N_SIZE = 32.
- DHV_SIZE, 4000: hypervector dimensions; CHUNKS = DHV_SIZE/M_SIZE = 250.
- CLASS_NUM, 26: number of classes. Memory depth ROWS_TOTAL = CLASS_NUM*CHUNKS = 6500.
- CLA_ADDR_WIDTH, 13: row address width; must satisfy ≥ clog2(ROWS_TOTAL).

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-high.
- class_write, in, 1: class byte write strobe.
- class_in, in, FTWIDTH: class byte.
- feat_valid, in, 1: one encoder beat is present.
- projections, in, N_SIZE+M_SIZE: beat sign bits; [N_SIZE-1:0] are feature signs, [N_SIZE+M_SIZE-1:N_SIZE] are dimension signs.
- features, in, N_SIZE*FTWIDTH: feature n occupies bits [n*8+7:n*8].
- write_done, out, 1: class memory is full (sticky).
- enc_out, out, M_SIZE*DIM_WIDTH: dimension m accumulator.
- enc_done, out, 1: one-cycle pulse, chunk complete.
- class_out, out, M_SIZE*FTWIDTH: class row read data; byte k is dimension k of the chunk.
- class_valid, out, 1: class_out is valid this cycle.
- class_idx, out, 8: class number of class_out.
- all_done, out, 1: all chunks read (sticky).

Behaviour:
- Reset:
  - All outputs 0, all counters 0, pending flag 0.
  - Memory contents are not cleared; write pointer returns to 0.
- Class memory load:
  - Each cycle with class_write=1 and write_done=0 stores class_in at linear byte index ptr, then ptr++.
  - Byte ptr lands in row ptr/M_SIZE, byte lane ptr%M_SIZE.
  - Linear index = class*DHV_SIZE + dim.
  - write_done rises the cycle after byte ROWS_TOTAL*M_SIZE-1 (104000th byte) is written.
  - Further writes are ignored; no wrap.
- Encoder:
  - feat_valid is ignored while write_done=0.
  - On each accepted beat, for every m: acc[m] += sum over n of (projections[n] XOR projections[N_SIZE+m] ? -f[n] : +f[n]).
  - Features are zero-extended; arithmetic wraps mod 2^DIM_WIDTH.
  - Beat counter runs 0..BEATS-1. On the beat with count BEATS-1, enc_out shows the final sum the next cycle, with enc_done=1 for that one cycle.
  - enc_out holds its value until the next accepted beat. That beat starts a new chunk: accumulators load the beat's sum rather than adding to it.
  - After CHUNKS chunks, further feat_valid is ignored.
- Read controller (states IDLE, READ):
  - IDLE → READ on enc_done, or on the pending flag being set.
  - In READ, issue address c*CHUNKS + chunk for c = 0..CLASS_NUM-1, one per cycle. Memory read is registered.
  - class_out/class_valid/class_idx=c appear 1 cycle after address c is issued, for CLASS_NUM consecutive cycles.
  - After the last address: chunk++ and return to IDLE.
  - all_done sets when chunk reaches CHUNKS, coincident with the last class_valid.
  - An enc_done arriving in READ sets the one-deep pending flag; READ restarts right after the current pass completes.
  - A second overrun is dropped (unreachable when CLASS_NUM < BEATS).
- Simultaneous class_write with read: writes are ignored once write_done=1, so there is no conflict.
- reset mid-operation aborts all phases; nothing completes afterwards.

Test Plan:
- Reset, then 104000 writes of class_in=2 → write_done rises exactly after the 104000th byte. A 104001st write with class_in=9 leaves memory unchanged.
- All projections 0, features all 1, 32 beats → enc_done pulse; every enc_out lane = 512 (0x0200).
- projections[16]=1, others 0, features all 1, 32 beats → enc_out[0]=0xFE00; lanes 1..15 = 0x0200.
- Load class bytes with value = (linear index mod 251). After chunk 0 → 26 consecutive class_valid cycles, class_idx 0..25. Class c byte k = ((c*4000+k) mod 251).
- Drive 250 chunks back-to-back with feat_valid held high → 250×26 valid reads; all_done=1 on the final valid; no extra enc_done.
- feat_valid before write_done → enc_out stays 0, no enc_done. Assert reset during READ → class_valid=0 next cycle, all counters 0.
